// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter and select sequencer for a shared 4:1 mux datapath.
// Grants one requester at a time, caps tenure at MAX_HOLD under contention.
module mux4_rr_arbiter #(
   parameter int DW       = 1,
   parameter int MAX_HOLD = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [3:0]    req,
   input  logic [DW-1:0] i0,
   input  logic [DW-1:0] i1,
   input  logic [DW-1:0] i2,
   input  logic [DW-1:0] i3,
   output logic [3:0]    gnt,
   output logic [1:0]    sel,
   output logic [DW-1:0] y,
   output logic          valid
);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   localparam logic [3:0] MAX_HOLD_C = 4'(MAX_HOLD);

   state_t      state_r, state_s;
   logic [1:0]  ptr_r, ptr_s;
   logic [3:0]  hold_cnt_r, hold_cnt_s;
   logic [3:0]  gnt_r, gnt_s;
   logic [1:0]  sel_r, sel_s;
   logic        valid_r, valid_s;
   logic [1:0]  win_s;

   // Scanning from the highest offset down lets the lowest offset from ptr win.
   function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
      logic [1:0] idx;
      rr_pick = p;
      for (int k = 3; k >= 0; k--) begin
         idx = p + 2'(k);
         if (r[idx]) begin
            rr_pick = idx;
         end else begin
            rr_pick = rr_pick;
         end
      end
   endfunction

   // Next-state and next-output decision for the arbiter FSM.
   always_comb begin
      state_s    = state_r;
      ptr_s      = ptr_r;
      hold_cnt_s = hold_cnt_r;
      gnt_s      = gnt_r;
      sel_s      = sel_r;
      valid_s    = valid_r;
      win_s      = rr_pick(req, ptr_r);
      case (state_r)
         IDLE: begin
            if (|req) begin
               state_s    = GRANT;
               gnt_s      = 4'b0001 << win_s;
               sel_s      = win_s;
               valid_s    = 1'b1;
               hold_cnt_s = 4'd1;
               ptr_s      = win_s + 2'd1;
            end else begin
               gnt_s      = 4'b0000;
               valid_s    = 1'b0;
               hold_cnt_s = 4'd0;
            end
         end
         GRANT: begin
            // ptr already points past the holder, so an expired holder is scanned last.
            if (req[sel_r] && (hold_cnt_r < MAX_HOLD_C)) begin
               hold_cnt_s = hold_cnt_r + 4'd1;
            end else if (|req) begin
               gnt_s      = 4'b0001 << win_s;
               sel_s      = win_s;
               valid_s    = 1'b1;
               hold_cnt_s = 4'd1;
               ptr_s      = win_s + 2'd1;
            end else begin
               state_s    = IDLE;
               gnt_s      = 4'b0000;
               valid_s    = 1'b0;
               hold_cnt_s = 4'd0;
            end
         end
         default: begin
            state_s    = IDLE;
            gnt_s      = 4'b0000;
            valid_s    = 1'b0;
            hold_cnt_s = 4'd0;
         end
      endcase
   end

   // State and registered-output update.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= IDLE;
         ptr_r      <= 2'd0;
         hold_cnt_r <= 4'd0;
         gnt_r      <= 4'b0000;
         sel_r      <= 2'd0;
         valid_r    <= 1'b0;
      end else begin
         state_r    <= state_s;
         ptr_r      <= ptr_s;
         hold_cnt_r <= hold_cnt_s;
         gnt_r      <= gnt_s;
         sel_r      <= sel_s;
         valid_r    <= valid_s;
      end
   end

   // Data path is unregistered so y tracks the selected input within the cycle.
   always_comb begin
      y = '0;
      if (valid_r) begin
         case (sel_r)
            2'd0:    y = i0;
            2'd1:    y = i1;
            2'd2:    y = i2;
            2'd3:    y = i3;
            default: y = '0;
         endcase
      end else begin
         y = '0;
      end
   end

   assign gnt   = gnt_r;
   assign sel   = sel_r;
   assign valid = valid_r;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed, table-driven bench for mux4_rr_arbiter (DW=1, MAX_HOLD=4).
module tb_mux4_rr_arbiter;

   logic       clk;
   logic       rst_n;
   logic [3:0] req;
   logic [0:0] i0, i1, i2, i3;
   logic [3:0] gnt;
   logic [1:0] sel;
   logic [0:0] y;
   logic       valid;

   int n_cmp;
   int n_fail;

   typedef struct {
      logic [3:0] req;
      logic [3:0] din;
      logic [3:0] gnt;
      logic [1:0] sel;
      logic       valid;
      logic       y;
   } vec_t;

   vec_t vecs[$];

   mux4_rr_arbiter #(.DW(1), .MAX_HOLD(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (req),
      .i0    (i0),
      .i1    (i1),
      .i2    (i2),
      .i3    (i3),
      .gnt   (gnt),
      .sel   (sel),
      .y     (y),
      .valid (valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_outs(input string tag, input logic [3:0] eg, input logic [1:0] es,
                             input logic ev, input logic ey);
      check({tag, ".gnt"},   gnt, eg);
      check({tag, ".sel"},   {2'b00, sel}, {2'b00, es});
      check({tag, ".valid"}, {3'b000, valid}, {3'b000, ev});
      check({tag, ".y"},     {3'b000, y}, {3'b000, ey});
   endtask

   task automatic set_din(input logic [3:0] d);
      i0 = d[0];
      i1 = d[1];
      i2 = d[2];
      i3 = d[3];
   endtask

   task automatic push(input logic [3:0] r, input logic [3:0] d, input logic [3:0] g,
                       input logic [1:0] s, input logic v, input logic yy);
      vec_t t;
      t.req = r; t.din = d; t.gnt = g; t.sel = s; t.valid = v; t.y = yy;
      vecs.push_back(t);
   endtask

   initial begin
      logic [1:0] g;
      logic [3:0] d;
      n_cmp  = 0;
      n_fail = 0;

      // Full contention: 4 cycles per requester, rotating 0,1,2,3,0.
      d = 4'b0101;
      for (int k = 0; k < 17; k++) begin
         g = 2'((k / 4) % 4);
         push(4'b1111, d, 4'b0001 << g, g, 1'b1, d[g]);
      end
      push(4'b0000, 4'b0101, 4'b0000, 2'd0, 1'b0, 1'b0);
      // Single requester across the MAX_HOLD boundary: continuous re-grant.
      for (int k = 0; k < 10; k++) begin
         push(4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1);
      end
      push(4'b0000, 4'b0100, 4'b0000, 2'd2, 1'b0, 1'b0);
      // Early release: 1 holds two cycles, drops while 3 waits.
      push(4'b0010, 4'b1000, 4'b0010, 2'd1, 1'b1, 1'b0);
      push(4'b1010, 4'b1000, 4'b0010, 2'd1, 1'b1, 1'b0);
      push(4'b1000, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b1);
      push(4'b0000, 4'b1000, 4'b0000, 2'd3, 1'b0, 1'b0);
      // Pointer wrap after requester 3's tenure.
      push(4'b1001, 4'b1001, 4'b0001, 2'd0, 1'b1, 1'b1);
      // Release to idle, then a fresh request.
      push(4'b0000, 4'b1001, 4'b0000, 2'd0, 1'b0, 1'b0);
      push(4'b0010, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b1);

      // Reset held with requests active.
      rst_n = 1'b0;
      req   = 4'b1111;
      set_din(4'b1111);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_outs("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
      rst_n = 1'b1;

      for (int v = 0; v < vecs.size(); v++) begin
         req = vecs[v].req;
         set_din(vecs[v].din);
         @(posedge clk);
         @(negedge clk);
         check_outs($sformatf("vec%0d", v), vecs[v].gnt, vecs[v].sel, vecs[v].valid, vecs[v].y);
      end

      // y follows the selected input with no clock edge.
      i1 = 1'b0;
      #1;
      check("y_follow_lo", {3'b000, y}, 4'b0000);
      i1 = 1'b1;
      #1;
      check("y_follow_hi", {3'b000, y}, 4'b0001);

      // Asynchronous reset mid-tenure, away from any clock edge.
      rst_n = 1'b0;
      #1;
      check_outs("async_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
      @(negedge clk);
      req = 4'b1111;
      set_din(4'b0001);
      rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_outs("post_rst_ptr0", 4'b0001, 2'd0, 1'b1, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
